// File: rtl/btn_event_if.sv
// Button event bus: debounced level and slow tick in, registered level and event strobes out.
// The slave side is the btn_event block, the master side is whoever drives the button level.
interface btn_event_if;
  logic tick;
  logic btn_db;
  logic held;
  logic press_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;

  modport master (
    output tick,
    output btn_db,
    input  held,
    input  press_pulse,
    input  short_pulse,
    input  long_pulse,
    input  repeat_pulse
  );

  modport slave (
    input  tick,
    input  btn_db,
    output held,
    output press_pulse,
    output short_pulse,
    output long_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/btn_event.sv
// btn_event: turns a debounced button level into one-clk press, short-release, long-press and
// auto-repeat strobes. Hold time is measured in ticks of the slow clk_div enable.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat in the long state). When undefined,
// repeat_pulse is tied low and the counter stays at zero while long.
module btn_event #(
  parameter int unsigned LONG_TICKS   = 100,
  parameter int unsigned REPEAT_TICKS = 20,
  parameter int unsigned CNT_W        = 8
) (
  input logic        clk,
  input logic        reset,
  btn_event_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPress = 2'd1,
    StLong  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_TICKS - 1);

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);
`else
  // Repeat spacing has no meaning without auto-repeat.
  logic unused_repeat_ticks;
  assign unused_repeat_ticks = ^REPEAT_TICKS;
  assign bus.repeat_pulse = 1'b0;
`endif

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             rise;
  logic             fall;

  // Edges are taken against the registered level, so they line up with held.
  assign rise = bus.btn_db & ~bus.held;
  assign fall = ~bus.btn_db & bus.held;

  // Event FSM: level register, tick counter and all strobes are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= StIdle;
      cnt             <= '0;
      bus.held        <= 1'b0;
      bus.press_pulse <= 1'b0;
      bus.short_pulse <= 1'b0;
      bus.long_pulse  <= 1'b0;
`ifdef BTN_REPEAT_EN
      bus.repeat_pulse <= 1'b0;
`endif
    end else begin
      bus.held        <= bus.btn_db;
      bus.press_pulse <= 1'b0;
      bus.short_pulse <= 1'b0;
      bus.long_pulse  <= 1'b0;
`ifdef BTN_REPEAT_EN
      bus.repeat_pulse <= 1'b0;
`endif
      unique case (state)
        StIdle: begin
          // A tick coinciding with the press is deliberately not counted.
          if (rise) begin
            bus.press_pulse <= 1'b1;
            cnt             <= '0;
            state           <= StPress;
          end
        end
        StPress: begin
          // Release wins over a simultaneous tick.
          if (fall) begin
            bus.short_pulse <= 1'b1;
            cnt             <= '0;
            state           <= StIdle;
          end else if (bus.tick) begin
            if (cnt == LongLast) begin
              bus.long_pulse <= 1'b1;
              cnt            <= '0;
              state          <= StLong;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        StLong: begin
          if (fall) begin
            cnt   <= '0;
            state <= StIdle;
          end
`ifdef BTN_REPEAT_EN
          else if (bus.tick) begin
            if (cnt == RepeatLast) begin
              bus.repeat_pulse <= 1'b1;
              cnt              <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
`endif
        end
        default: begin
          cnt   <= '0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: LONG_TICKS=4, REPEAT_TICKS=2, tick every 4th clk (or every clk in one
// scenario). A tick-count model predicts every output each cycle; literal pulse counts per
// scenario pin the model.
module tb_btn_event;
  localparam int LongTicks   = 4;
  localparam int RepeatTicks = 2;
`ifdef BTN_REPEAT_EN
  localparam bit RepeatEn = 1'b1;
`else
  localparam bit RepeatEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  btn_event_if bus ();

  btn_event #(
    .LONG_TICKS  (LongTicks),
    .REPEAT_TICKS(RepeatTicks),
    .CNT_W       (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ticks counted since the press; long at exactly LongTicks, repeat every
  // RepeatTicks beyond that; short only if released before reaching LongTicks.
  logic e_held, e_press, e_short, e_long, e_rep;
  logic m_hold;
  int   m_ticks;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_held  <= 1'b0;
      e_press <= 1'b0;
      e_short <= 1'b0;
      e_long  <= 1'b0;
      e_rep   <= 1'b0;
      m_hold  <= 1'b0;
      m_ticks <= 0;
    end else begin
      e_held  <= bus.btn_db;
      e_press <= 1'b0;
      e_short <= 1'b0;
      e_long  <= 1'b0;
      e_rep   <= 1'b0;
      if (!m_hold) begin
        if (bus.btn_db && !e_held) begin
          e_press <= 1'b1;
          m_hold  <= 1'b1;
          m_ticks <= 0;
        end
      end else if (!bus.btn_db) begin
        m_hold  <= 1'b0;
        e_short <= (m_ticks < LongTicks);
      end else if (bus.tick) begin
        m_ticks <= m_ticks + 1;
        e_long  <= (m_ticks + 1 == LongTicks);
        e_rep   <= RepeatEn && (m_ticks + 1 > LongTicks) &&
                   ((m_ticks + 1 - LongTicks) % RepeatTicks == 0);
      end
    end
  end

  // Per-cycle compare plus pulse tallies for the literal checks.
  int seen_press = 0, seen_short = 0, seen_long = 0, seen_rep = 0;

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      chk("held", bus.held, e_held);
      chk("press_pulse", bus.press_pulse, e_press);
      chk("short_pulse", bus.short_pulse, e_short);
      chk("long_pulse", bus.long_pulse, e_long);
      chk("repeat_pulse", bus.repeat_pulse, e_rep);
      seen_press += int'(bus.press_pulse);
      seen_short += int'(bus.short_pulse);
      seen_long  += int'(bus.long_pulse);
      seen_rep   += int'(bus.repeat_pulse);
    end
  end

  int phase = 0;
  bit tick_all = 1'b0;

  // One clk of stimulus, driven on the falling edge.
  task automatic cyc(input logic b);
    @(negedge clk);
    bus.btn_db = b;
    bus.tick   = tick_all ? 1'b1 : (phase == 3);
    phase      = (phase + 1) % 4;
  endtask

  task automatic run(input logic b, input int n);
    repeat (n) cyc(b);
  endtask

  // Keep the level until the next cyc() call carries a tick.
  task automatic align(input logic b);
    while (phase != 3) cyc(b);
  endtask

  // Keep the level for k ticks, ending on the cycle that carries the k-th.
  task automatic hold_ticks(input logic b, input int k);
    int t = 0;
    while (t < k) begin
      cyc(b);
      if (bus.tick) t++;
    end
  endtask

  task automatic clr_seen();
    seen_press = 0;
    seen_short = 0;
    seen_long  = 0;
    seen_rep   = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " held"}, bus.held, 0);
    chk({tag, " press"}, bus.press_pulse, 0);
    chk({tag, " short"}, bus.short_pulse, 0);
    chk({tag, " long"}, bus.long_pulse, 0);
    chk({tag, " repeat"}, bus.repeat_pulse, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.btn_db = 1'b0;
    bus.tick   = 1'b0;
    #1;
    chk_all_zero("reset state");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Press, release after 2 ticks: press at N+1, short one cycle after the fall.
    run(1'b0, 3);
    clr_seen();
    cyc(1'b1);
    @(posedge clk);
    #1;
    chk("s2 press at N+1", bus.press_pulse, 1);
    hold_ticks(1'b1, 2);
    cyc(1'b0);
    @(posedge clk);
    #1;
    chk("s2 short after fall", bus.short_pulse, 1);
    run(1'b0, 4);
    chk("s2 presses", seen_press, 1);
    chk("s2 shorts", seen_short, 1);
    chk("s2 longs", seen_long, 0);
    chk("s2 repeats", seen_rep, 0);

    // Hold for 10 ticks: long after the 4th, repeats after 6/8/10 when enabled.
    clr_seen();
    cyc(1'b1);
    hold_ticks(1'b1, 10);
    run(1'b1, 2);
    cyc(1'b0);
    run(1'b0, 3);
    chk("s3 longs", seen_long, 1);
    chk("s3 repeats", seen_rep, RepeatEn ? 3 : 0);
    chk("s3 shorts", seen_short, 0);

    // Release coincident with the 4th tick: short wins, no long.
    clr_seen();
    cyc(1'b1);
    hold_ticks(1'b1, 3);
    align(1'b1);
    cyc(1'b0);
    run(1'b0, 3);
    chk("s5 shorts", seen_short, 1);
    chk("s5 longs", seen_long, 0);

    // Rise coincident with a tick: that tick is not counted.
    clr_seen();
    run(1'b0, 2);
    align(1'b0);
    cyc(1'b1);
    hold_ticks(1'b1, 3);
    run(1'b1, 1);
    chk("s6 no long after 3 ticks", seen_long, 0);
    hold_ticks(1'b1, 1);
    run(1'b1, 1);
    chk("s6 long after 4 ticks", seen_long, 1);
    cyc(1'b0);
    run(1'b0, 3);
    chk("s6 presses", seen_press, 1);

    // Tick held high: one count per clk.
    tick_all = 1'b1;
    clr_seen();
    cyc(1'b1);
    run(1'b1, 3);
    run(1'b1, 1);
    chk("tick-high no long after 3 clks", seen_long, 0);
    run(1'b1, 1);
    chk("tick-high long after 4 clks", seen_long, 1);
    cyc(1'b0);
    tick_all = 1'b0;
    run(1'b0, 3);

    // Reset mid-hold with the button later released: outputs clear at once, no pulses.
    cyc(1'b1);
    hold_ticks(1'b1, 2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    cyc(1'b0);
    @(negedge clk);
    reset = 1'b0;
    clr_seen();
    run(1'b0, 6);
    chk("reset-release presses", seen_press, 0);
    chk("reset-release shorts", seen_short, 0);

    // Reset mid-hold with the button still down: a fresh press after release.
    cyc(1'b1);
    hold_ticks(1'b1, 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clr_seen();
    run(1'b1, 3);
    chk("reset-held new press", seen_press, 1);
    cyc(1'b0);
    run(1'b0, 3);
    chk("reset-held short", seen_short, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
